round_normalize_pipe: RTL and testbench
=======================================

# round_normalize_pipe

Pipelined, parametrised leading-one normaliser and rounder for the approximate-multiplier datapath. Each accepted operand is reduced to a normalised MANT_WIDTH-bit mantissa and an exponent equal to its leading-one index, including correct carry-out on round-up. It sits between the partial-product operand registers and the log/shift multiplier core. Traffic uses valid/ready handshakes at one operand per cycle.

## Interface
- WIDTH, 16: input operand width, ≥ 4.
- MANT_WIDTH, 4: output mantissa width, 2 ≤ MANT_WIDTH ≤ WIDTH.
- LOG2_WIDTH, 4: $clog2(WIDTH); the exponent is LOG2_WIDTH+1 bits wide.
- clk  input  1  sole clock; every register is updated on its rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  the operand is valid.
- in_ready  output  1  the block accepts the operand this cycle.
- in_operand  input  WIDTH  unsigned operand.
- out_valid  output  1  the result is valid.
- out_ready  input  1  downstream accepts the result.
- out_mant  output  MANT_WIDTH  rounded mantissa; MSB is the leading one.
- out_exp  output  LOG2_WIDTH+1  leading-one index, plus 1 on rounding carry-out.
- out_zero  output  1  the operand was zero.

## Operation
- S1, detect: K = index of the highest set bit of in_operand; zero = (operand == 0). The operand, K and zero are registered.
- S2, normalise: norm = operand << (WIDTH-1-K), which places the leading one at bit WIDTH-1. The shift is computed in WIDTH bits with no overflow.
- S3, round:
  - top = norm[WIDTH-1 -: MANT_WIDTH].
  - rbit = norm[WIDTH-1-MANT_WIDTH].
  - sticky = OR of all norm bits below rbit.
  - Increment top when the round condition holds (see Configuration).
  - If top is all ones and is incremented: out_mant = 1 followed by zeros, and out_exp = K+1, which can reach WIDTH.
  - Otherwise out_exp = K.
- If MANT_WIDTH == WIDTH, there is no round bit: out_mant = norm and out_exp = K.
- Zero operand: out_zero = 1, out_mant = 0, out_exp = 0, and no rounding is applied.

## Timing
- Latency: 3 cycles from in_valid && in_ready to out_valid, given out_ready held high. Throughput is 1 result per cycle.
- Each stage holds a valid bit. A stage loads when it is empty or when its contents move forward in the same cycle.
- in_ready = !s1_valid || s1_advance. The ready chain is combinational from out_ready.
- Once out_valid is high, out_mant, out_exp and out_zero stay stable until out_ready is sampled high. Stalls never drop or duplicate a result.
- A transfer in and a transfer out in the same cycle are both honoured. There is no bubble with out_ready held high.
- Reset values: all stage valids are 0, out_valid = 0, in_ready = 1, and out_mant, out_exp, out_zero are 0.
- Reset asserted mid-stream flushes every in-flight operand; nothing is emitted after reset for those operands. in_ready is 1 in the first cycle after rst deasserts.
- An operand with in_valid high while in_ready is low is not consumed; the upstream holds it.

## Configuration
- RND_NORM_RNE_EN defined: round-to-nearest-even. Round up when rbit && (sticky || top[0]).
- RND_NORM_RNE_EN undefined: round-half-up, using the round bit only. Round up when rbit, and sticky logic is not built.

## Structure
- Package rnd_norm_pkg holds the following shared items:
  - a localparam helper computing the exponent width (LOG2_WIDTH+1);
  - a round_mode_e enum (RND_HALF_UP, RND_NEAREST_EVEN), used for debug and cover reporting;
  - a packed struct for a stage payload: operand/norm, K, zero.
- One sub-module, leading_one_detect (WIDTH, LOG2_WIDTH). It is a combinational priority encoder producing K and zero, and is instantiated in S1.

## Test plan
- **Basic, no round-up** (WIDTH=16, MANT=4, out_ready=1): 0x00B0 → mant 4'b1011, exp 7, zero 0, exactly 3 cycles after acceptance. 0x0001 → mant 4'b1000, exp 0.
- **Round-up and carry-out:** 0x00B8 → mant 4'b1100, exp 7. 0x00F8 → mant 4'b1000, exp 8. 0xFFFF → mant 4'b1000, exp 16.
- **Tie case:** 0x0088 → mant 4'b1000 with RND_NORM_RNE_EN; mant 4'b1001 without it. 0x0098 → mant 4'b1010 in both builds.
- **Zero operand:** 0x0000 → out_zero 1, mant 0, exp 0.
- **Back-pressure:** stream 8 operands with out_ready toggling randomly. Required:
  - results appear in order with none lost or duplicated;
  - outputs stay stable while stalled;
  - in_ready is low when the pipeline is full and out_ready is low.
- **Mid-stream reset:** assert rst for 1 cycle with 3 operands in flight. Required: out_valid is 0 the next cycle, none of the 3 results ever appears, and the next accepted operand completes with 3-cycle latency.

Source files
------------

// File: rtl/rnd_norm_pkg.sv
// Shared types and helpers for the leading-one normaliser / rounder pipeline.
// Defining RND_NORM_RNE_EN selects round-to-nearest-even; otherwise round-half-up.
package rnd_norm_pkg;

    localparam int RND_NORM_DEF_WIDTH      = 16;
    localparam int RND_NORM_DEF_LOG2_WIDTH = 4;

    typedef enum logic [0:0] {
        RND_HALF_UP      = 1'b0,
        RND_NEAREST_EVEN = 1'b1
    } round_mode_e;

`ifdef RND_NORM_RNE_EN
    localparam round_mode_e RND_NORM_MODE = RND_NEAREST_EVEN;
`else
    localparam round_mode_e RND_NORM_MODE = RND_HALF_UP;
`endif

    // Exponent carries one extra bit so a rounding carry at the top index fits.
    function automatic int exp_width(input int log2_width);
        return log2_width + 32'sd1;
    endfunction

    typedef struct packed {
        logic [RND_NORM_DEF_WIDTH-1:0]      data;
        logic [RND_NORM_DEF_LOG2_WIDTH-1:0] k;
        logic                               zero;
    } stage_payload_t;

endpackage

// File: rtl/leading_one_detect.sv
// Combinational priority encoder: index of the highest set bit plus a zero flag.
module leading_one_detect
#(
    parameter int WIDTH      = 16,
    parameter int LOG2_WIDTH = 4
) (
    input  logic [WIDTH-1:0]      operand,
    output logic [LOG2_WIDTH-1:0] k,
    output logic                  zero
);

    // Ascending scan so the highest set bit wins.
    always_comb begin
        k    = {LOG2_WIDTH{1'b0}};
        zero = ~|operand;
        for (int i = 0; i < WIDTH; i++) begin
            k = operand[i] ? LOG2_WIDTH'(i) : k;
        end
    end

endmodule

// File: rtl/round_normalize_pipe.sv
// Three-stage valid/ready pipeline: detect leading one, normalise, round.
// Build option RND_NORM_RNE_EN selects round-to-nearest-even instead of round-half-up.
module round_normalize_pipe
    import rnd_norm_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int MANT_WIDTH = 4,
    parameter int LOG2_WIDTH = $clog2(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_operand,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [MANT_WIDTH-1:0] out_mant,
    output logic [LOG2_WIDTH:0]   out_exp,
    output logic                  out_zero
);

    localparam int                    EXP_W   = exp_width(LOG2_WIDTH);
    localparam logic [LOG2_WIDTH-1:0] MSB_IDX = LOG2_WIDTH'(WIDTH - 1);

    typedef struct packed {
        logic [WIDTH-1:0]      data;
        logic [LOG2_WIDTH-1:0] k;
        logic                  zero;
    } stage_t;

    logic                  s1_valid_r;
    logic                  s2_valid_r;
    logic                  out_valid_r;
    stage_t                s1_r;
    stage_t                s2_r;
    logic [MANT_WIDTH-1:0] out_mant_r;
    logic [EXP_W-1:0]      out_exp_r;
    logic                  out_zero_r;

    logic                  out_load_s;
    logic                  s2_load_s;
    logic                  in_ready_s;
    logic [LOG2_WIDTH-1:0] lod_k_s;
    logic                  lod_zero_s;
    logic [LOG2_WIDTH-1:0] shift_s;
    logic [WIDTH-1:0]      norm_s;
    logic [MANT_WIDTH-1:0] top_s;
    logic                  round_up_s;
    logic [MANT_WIDTH:0]   sum_s;
    logic [MANT_WIDTH-1:0] mant_s;
    logic [EXP_W-1:0]      exp_s;

    // A stage may load when empty or when its current content leaves this cycle.
    assign out_load_s = !out_valid_r || out_ready;
    assign s2_load_s  = !s2_valid_r || out_load_s;
    assign in_ready_s = !s1_valid_r || s2_load_s;
    assign in_ready   = in_ready_s;

    leading_one_detect #(
        .WIDTH      (WIDTH),
        .LOG2_WIDTH (LOG2_WIDTH)
    ) u_lod (
        .operand (in_operand),
        .k       (lod_k_s),
        .zero    (lod_zero_s)
    );

    // S1: capture operand together with its leading-one index.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_r       <= '0;
        end else if (in_ready_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_r <= '{data: in_operand, k: lod_k_s, zero: lod_zero_s};
            end
        end
    end

    assign shift_s = MSB_IDX - s1_r.k;
    assign norm_s  = s1_r.data << shift_s;

    // S2: register the operand shifted so its leading one sits at the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_r       <= '0;
        end else if (s2_load_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_r <= '{data: norm_s, k: s1_r.k, zero: s1_r.zero};
            end
        end
    end

    generate
        if (MANT_WIDTH == WIDTH) begin : g_no_round
            assign top_s      = s2_r.data;
            assign round_up_s = 1'b0;
        end else begin : g_round
            logic rbit_s;
            assign top_s  = s2_r.data[WIDTH-1 -: MANT_WIDTH];
            assign rbit_s = s2_r.data[WIDTH-1-MANT_WIDTH];
            if (MANT_WIDTH == WIDTH - 1) begin : g_no_sticky
`ifdef RND_NORM_RNE_EN
                assign round_up_s = rbit_s && top_s[0];
`else
                assign round_up_s = rbit_s;
`endif
            end else begin : g_sticky
`ifdef RND_NORM_RNE_EN
                logic sticky_s;
                assign sticky_s   = |s2_r.data[WIDTH-2-MANT_WIDTH:0];
                assign round_up_s = rbit_s && (sticky_s || top_s[0]);
`else
                // Bits below the round bit do not influence half-up rounding.
                logic unused_low_s;
                assign unused_low_s = ^s2_r.data[WIDTH-2-MANT_WIDTH:0];
                assign round_up_s   = rbit_s;
`endif
            end
        end
    endgenerate

    // Apply the increment; a carry out renormalises to 1000.. and bumps the exponent.
    always_comb begin
        sum_s  = {1'b0, top_s} + {{MANT_WIDTH{1'b0}}, round_up_s};
        mant_s = sum_s[MANT_WIDTH-1:0];
        exp_s  = {1'b0, s2_r.k};
        if (s2_r.zero) begin
            mant_s = {MANT_WIDTH{1'b0}};
            exp_s  = {EXP_W{1'b0}};
        end else if (sum_s[MANT_WIDTH]) begin
            mant_s = {1'b1, {(MANT_WIDTH-1){1'b0}}};
            exp_s  = {1'b0, s2_r.k} + {{LOG2_WIDTH{1'b0}}, 1'b1};
        end else begin
            mant_s = sum_s[MANT_WIDTH-1:0];
            exp_s  = {1'b0, s2_r.k};
        end
    end

    // S3: output register, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_mant_r  <= {MANT_WIDTH{1'b0}};
            out_exp_r   <= {EXP_W{1'b0}};
            out_zero_r  <= 1'b0;
        end else if (out_load_s) begin
            out_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                out_mant_r <= mant_s;
                out_exp_r  <= exp_s;
                out_zero_r <= s2_r.zero;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_mant  = out_mant_r;
    assign out_exp   = out_exp_r;
    assign out_zero  = out_zero_r;

endmodule

// File: tb/tb_round_normalize_pipe.sv
// Self-checking bench for round_normalize_pipe (WIDTH=16, MANT_WIDTH=4), scoreboard based.
module tb_round_normalize_pipe;
    import rnd_norm_pkg::*;

    typedef struct packed {
        logic [3:0] mant;
        logic [4:0] exp;
        logic       zero;
    } exp_t;

    typedef struct {
        logic [15:0] op;
        exp_t        e;
    } vec_t;

    typedef struct {
        exp_t e;
        int   acc;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_operand;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_mant;
    logic [4:0]  out_exp;
    logic        out_zero;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_in = 0;
    int   n_out = 0;
    int   n_flushed = 0;
    bit   check_lat = 1'b0;
    bit   bp_mode = 1'b0;
    exp_t cur_exp;
    sb_t  sb[$];
    bit         hold_v = 1'b0;
    logic [3:0] hold_m;
    logic [4:0] hold_e;
    logic       hold_z;
    vec_t vecs[15];

    round_normalize_pipe #(.WIDTH(16), .MANT_WIDTH(4), .LOG2_WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_operand (in_operand),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mant   (out_mant),
        .out_exp    (out_exp),
        .out_zero   (out_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (bp_mode) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: mantissa taken arithmetically from the operand, no shifting to the MSB.
    function automatic exp_t ref_model(input logic [15:0] op);
        exp_t        r;
        int          k;
        int          sh;
        bit          found;
        logic [15:0] top;
        logic        rb;
        logic        up;
`ifdef RND_NORM_RNE_EN
        logic        st;
`endif
        r = '{mant: 4'd0, exp: 5'd0, zero: 1'b1};
        if (op == 16'd0) return r;
        k = 0;
        found = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (!found && op[i]) begin
                k = i;
                found = 1'b1;
            end
        end
        r.zero = 1'b0;
        if (k < 4) begin
            r.mant = 4'(op << (3 - k));
            r.exp  = 5'(k);
        end else begin
            sh  = k - 3;
            top = op >> sh;
            rb  = op[sh-1];
`ifdef RND_NORM_RNE_EN
            st  = (sh >= 2) ? ((op & ((16'd1 << (sh - 1)) - 16'd1)) != 16'd0) : 1'b0;
            up  = rb && (st || top[0]);
`else
            up  = rb;
`endif
            top = top + {15'd0, up};
            if (top == 16'd16) begin
                r.mant = 4'b1000;
                r.exp  = 5'(k + 1);
            end else begin
                r.mant = top[3:0];
                r.exp  = 5'(k);
            end
        end
        return r;
    endfunction

    // Monitor: full-pipe ready, stall stability, scoreboard pop and push.
    always @(negedge clk) begin
        sb_t s;
        if (rst) begin
            n_flushed += sb.size();
            sb.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_mant", 32'(out_mant), 32'(hold_m));
                chk("stall_exp", 32'(out_exp), 32'(hold_e));
                chk("stall_zero", 32'(out_zero), 32'(hold_z));
            end
            if (sb.size() >= 3 && !out_ready) chk("full_in_ready", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    s = sb.pop_front();
                    n_out++;
                    chk("mant", 32'(out_mant), 32'(s.e.mant));
                    chk("exp", 32'(out_exp), 32'(s.e.exp));
                    chk("zero", 32'(out_zero), 32'(s.e.zero));
                    if (check_lat) chk("latency", 32'(cyc - s.acc), 32'd3);
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back('{e: cur_exp, acc: cyc});
                n_in++;
            end
            hold_v = out_valid && !out_ready;
            hold_m = out_mant;
            hold_e = out_exp;
            hold_z = out_zero;
        end
    end

    task automatic send(input logic [15:0] op, input exp_t e);
        int t;
        bit done;
        t = 0;
        done = 1'b0;
        in_operand = op;
        cur_exp = e;
        in_valid = 1'b1;
        while (!done && t < 100) begin
            @(negedge clk);
            done = in_ready;
            t++;
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", 32'(t), 32'd0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || out_valid) && t < 100) begin
            @(posedge clk);
            #2;
            t++;
        end
        chk("drain_timeout", 32'(t >= 100), 32'd0);
    endtask

    initial begin
        logic [15:0] rop;
        vecs[0]  = '{16'h00B0, '{4'b1011, 5'd7,  1'b0}};
        vecs[1]  = '{16'h0001, '{4'b1000, 5'd0,  1'b0}};
        vecs[2]  = '{16'h00B8, '{4'b1100, 5'd7,  1'b0}};
        vecs[3]  = '{16'h00F8, '{4'b1000, 5'd8,  1'b0}};
        vecs[4]  = '{16'hFFFF, '{4'b1000, 5'd16, 1'b0}};
`ifdef RND_NORM_RNE_EN
        vecs[5]  = '{16'h0088, '{4'b1000, 5'd7,  1'b0}};
        vecs[6]  = '{16'h00A8, '{4'b1010, 5'd7,  1'b0}};
`else
        vecs[5]  = '{16'h0088, '{4'b1001, 5'd7,  1'b0}};
        vecs[6]  = '{16'h00A8, '{4'b1011, 5'd7,  1'b0}};
`endif
        vecs[7]  = '{16'h0098, '{4'b1010, 5'd7,  1'b0}};
        vecs[8]  = '{16'h0000, '{4'b0000, 5'd0,  1'b1}};
        vecs[9]  = '{16'h8000, '{4'b1000, 5'd15, 1'b0}};
        vecs[10] = '{16'h0007, '{4'b1110, 5'd2,  1'b0}};
        vecs[11] = '{16'h000F, '{4'b1111, 5'd3,  1'b0}};
        vecs[12] = '{16'h001F, '{4'b1000, 5'd5,  1'b0}};
        vecs[13] = '{16'h0014, '{4'b1010, 5'd4,  1'b0}};
        vecs[14] = '{16'h0089, '{4'b1001, 5'd7,  1'b0}};

        $display("round mode: %s", RND_NORM_MODE.name());
        rst = 1'b1;
        in_valid = 1'b0;
        in_operand = 16'd0;
        out_ready = 1'b1;
        cur_exp = '{4'd0, 5'd0, 1'b0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_outputs", 32'({out_mant, out_exp, out_zero}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Directed vectors, back to back, downstream always ready.
        check_lat = 1'b1;
        foreach (vecs[i]) send(vecs[i].op, vecs[i].e);
        in_valid = 1'b0;
        drain();

        // Random back-pressure stream.
        check_lat = 1'b0;
        bp_mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rop = (i == 5) ? 16'd0 : 16'($urandom_range(0, 65535));
            send(rop, ref_model(rop));
        end
        in_valid = 1'b0;
        bp_mode = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        // Mid-stream reset with three operands held in a stalled pipe.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(16'h1234, ref_model(16'h1234));
        send(16'h00B0, ref_model(16'h00B0));
        send(16'h0F0F, ref_model(16'h0F0F));
        in_valid = 1'b0;
        @(negedge clk);
        chk("flight_count", 32'(sb.size()), 32'd3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_lat = 1'b1;
        send(16'h0098, ref_model(16'h0098));
        in_valid = 1'b0;
        drain();

        chk("conservation", 32'(n_out + n_flushed), 32'(n_in));
        chk("flushed_count", 32'(n_flushed), 32'd3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
